// File: rtl/dds_sequencer.sv
// Note sequencer feeding a DDS: steps through a host-written table of
// {tuning word, duration} entries and drives m/set/en with registered outputs.
module dds_sequencer #(
   parameter int TICK_DIV = 12000,
   parameter int N_STEPS  = 8,
   parameter int AW       = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_word,
   input  logic [15:0]   wr_dur,
   input  logic          start,
   input  logic          stop,
   input  logic          loop,
   output logic [31:0]   m,
   output logic          set,
   output logic          en,
   output logic [AW-1:0] step,
   output logic          busy,
   output logic          done
);

   localparam int PW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      PLAY
   } state_t;

   state_t state, state_nxt;

   logic [31:0]   word_mem [N_STEPS];
   logic [15:0]   dur_mem  [N_STEPS];

   logic [PW-1:0] prescaler, prescaler_nxt;
   logic [15:0]   remaining, remaining_nxt;
   logic [31:0]   m_nxt;
   logic          set_nxt, en_nxt, busy_nxt, done_nxt;
   logic [AW-1:0] step_nxt;

   logic [AW-1:0] nx_idx, ld_idx;
   logic [31:0]   e0_word, nx_word, ld_word;
   logic [15:0]   e0_dur, nx_dur, ld_dur;
   logic          tick, wrap;
   logic          do_load, sel0, do_finish, do_abort;

   // Table storage is deliberately not reset; the host fills it before start.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         word_mem[wr_addr] <= wr_word;
         dur_mem[wr_addr]  <= wr_dur;
      end
   end

   // A write landing on the same edge as a load must be seen by that load.
   assign nx_idx  = step + 1'b1;
   assign e0_word = (wr_en && wr_addr == '0)     ? wr_word : word_mem[0];
   assign e0_dur  = (wr_en && wr_addr == '0)     ? wr_dur  : dur_mem[0];
   assign nx_word = (wr_en && wr_addr == nx_idx) ? wr_word : word_mem[nx_idx];
   assign nx_dur  = (wr_en && wr_addr == nx_idx) ? wr_dur  : dur_mem[nx_idx];

   assign ld_idx  = sel0 ? '0      : nx_idx;
   assign ld_word = sel0 ? e0_word : nx_word;
   assign ld_dur  = sel0 ? e0_dur  : nx_dur;

   assign tick = (state == PLAY) && (prescaler == PW'(TICK_DIV - 1));
   assign wrap = (step == AW'(N_STEPS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      do_load   = 1'b0;
      sel0      = 1'b0;
      do_finish = 1'b0;
      do_abort  = 1'b0;
      case (state)
         IDLE: begin
            if (start && !stop) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (stop) begin
               state_nxt = IDLE;
               do_abort  = 1'b1;
            end else if (e0_dur != '0) begin
               state_nxt = PLAY;
               do_load   = 1'b1;
               sel0      = 1'b1;
            end else begin
               state_nxt = IDLE;
               do_finish = 1'b1;
            end
         end
         PLAY: begin
            if (stop) begin
               state_nxt = IDLE;
               do_abort  = 1'b1;
            end else if (tick && remaining == 16'd1) begin
               // The tick that would take remaining to zero hands over to the next entry.
               if (!wrap && nx_dur != '0) begin
                  do_load = 1'b1;
               end else if (loop && e0_dur != '0) begin
                  do_load = 1'b1;
                  sel0    = 1'b1;
               end else begin
                  state_nxt = IDLE;
                  do_finish = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_comb begin
      prescaler_nxt = prescaler;
      remaining_nxt = remaining;
      m_nxt         = m;
      set_nxt       = 1'b0;
      en_nxt        = en;
      step_nxt      = step;
      busy_nxt      = busy;
      done_nxt      = 1'b0;
      if (state == PLAY) begin
         if (tick) begin
            prescaler_nxt = '0;
            remaining_nxt = remaining - 16'd1;
         end else begin
            prescaler_nxt = prescaler + 1'b1;
         end
      end
      if (do_load) begin
         m_nxt         = ld_word;
         set_nxt       = 1'b1;
         en_nxt        = (ld_word != '0);
         step_nxt      = ld_idx;
         busy_nxt      = 1'b1;
         prescaler_nxt = '0;
         remaining_nxt = ld_dur;
      end
      if (do_finish || do_abort) begin
         en_nxt        = 1'b0;
         busy_nxt      = 1'b0;
         prescaler_nxt = '0;
         remaining_nxt = '0;
      end
      if (do_finish) begin
         done_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         remaining <= '0;
         m         <= '0;
         set       <= 1'b0;
         en        <= 1'b0;
         step      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         prescaler <= prescaler_nxt;
         remaining <= remaining_nxt;
         m         <= m_nxt;
         set       <= set_nxt;
         en        <= en_nxt;
         step      <= step_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_dds_sequencer.sv
// Directed vector bench for dds_sequencer with TICK_DIV=4: each vector holds
// its inputs for n clock edges, then compares every output against hand values.
module tb_dds_sequencer;

   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_word;
   logic [15:0]   wr_dur;
   logic          start, stop, loop;
   logic [31:0]   m;
   logic          set, en, busy, done;
   logic [AW-1:0] step;

   int vec_count = 0;
   int err_count = 0;

   typedef struct {
      string         name;
      int            n;
      logic          wr_en;
      logic [AW-1:0] wr_addr;
      logic [31:0]   wr_word;
      logic [15:0]   wr_dur;
      logic          start, stop, loop;
      logic          chk;
      logic [31:0]   m;
      logic          set, en;
      logic [AW-1:0] step;
      logic          busy, done;
   } vec_t;

   vec_t vecs[$];

   dds_sequencer #(.TICK_DIV(4), .N_STEPS(8), .AW(AW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_word(wr_word), .wr_dur(wr_dur),
      .start(start), .stop(stop), .loop(loop),
      .m(m), .set(set), .en(en), .step(step), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic push(input string nm, input int n, input logic we, input logic [AW-1:0] wa,
                       input logic [31:0] ww, input logic [15:0] wd,
                       input logic st, input logic sp, input logic lp, input logic ck,
                       input logic [31:0] em, input logic es, input logic ee,
                       input logic [AW-1:0] est, input logic eb, input logic ed);
      vec_t v;
      v.name = nm; v.n = n; v.wr_en = we; v.wr_addr = wa; v.wr_word = ww; v.wr_dur = wd;
      v.start = st; v.stop = sp; v.loop = lp; v.chk = ck;
      v.m = em; v.set = es; v.en = ee; v.step = est; v.busy = eb; v.done = ed;
      vecs.push_back(v);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] w, input logic [15:0] d);
      push("wr", 1, 1'b1, a, w, d, 1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic cy(input string nm, input int n, input logic st, input logic sp, input logic lp,
                     input logic [31:0] em, input logic es, input logic ee,
                     input logic [AW-1:0] est, input logic eb, input logic ed);
      push(nm, n, 1'b0, '0, '0, '0, st, sp, lp, 1'b1, em, es, ee, est, eb, ed);
   endtask

   task automatic checkOutput(input string nm, input logic [31:0] em, input logic es,
                              input logic ee, input logic [AW-1:0] est,
                              input logic eb, input logic ed);
      vec_count++;
      if (m !== em || set !== es || en !== ee || step !== est || busy !== eb || done !== ed) begin
         err_count++;
         $display("[TB] FAIL %s: got m=%0d set=%b en=%b step=%0d busy=%b done=%b, expected m=%0d set=%b en=%b step=%0d busy=%b done=%b",
                  nm, m, set, en, step, busy, done, em, es, ee, est, eb, ed);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled on the falling edge after the last rising edge.
   task automatic applyStimulus(input vec_t v);
      wr_en = v.wr_en; wr_addr = v.wr_addr; wr_word = v.wr_word; wr_dur = v.wr_dur;
      start = v.start; stop = v.stop; loop = v.loop;
      repeat (v.n) @(posedge clk);
      @(negedge clk);
      if (v.chk) checkOutput(v.name, v.m, v.set, v.en, v.step, v.busy, v.done);
   endtask

   localparam logic [31:0] F440 = 32'd157482;
   localparam logic [31:0] F880 = 32'd314964;

   initial begin
      rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_word = '0; wr_dur = '0;
      start = 1'b0; stop = 1'b0; loop = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset", '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      rst_n = 1'b1;

      wr(0, F440, 3); wr(1, F880, 2); wr(2, 0, 0);

      // Basic playback
      cy("a_start",  1, 1, 0, 0, 0,    0, 0, 0, 0, 0);
      cy("a_load0",  1, 0, 0, 0, F440, 1, 1, 0, 1, 0);
      cy("a_setlow", 1, 0, 0, 0, F440, 0, 1, 0, 1, 0);
      cy("a_hold0", 10, 0, 0, 0, F440, 0, 1, 0, 1, 0);
      cy("a_load1",  1, 0, 0, 0, F880, 1, 1, 1, 1, 0);
      cy("a_hold1",  7, 0, 0, 0, F880, 0, 1, 1, 1, 0);
      cy("a_done",   1, 0, 0, 0, F880, 0, 0, 1, 0, 1);
      cy("a_idle",   1, 0, 0, 0, F880, 0, 0, 1, 0, 0);

      // Looping, then loop dropped for the second pass
      cy("b_start",  1, 1, 0, 1, F880, 0, 0, 1, 0, 0);
      cy("b_load0",  1, 0, 0, 1, F440, 1, 1, 0, 1, 0);
      cy("b_hold0", 11, 0, 0, 1, F440, 0, 1, 0, 1, 0);
      cy("b_load1",  1, 0, 0, 1, F880, 1, 1, 1, 1, 0);
      cy("b_hold1",  7, 0, 0, 1, F880, 0, 1, 1, 1, 0);
      cy("b_reload", 1, 0, 0, 1, F440, 1, 1, 0, 1, 0);
      cy("b_hold0b",11, 0, 0, 0, F440, 0, 1, 0, 1, 0);
      cy("b_load1b", 1, 0, 0, 0, F880, 1, 1, 1, 1, 0);
      cy("b_hold1b", 7, 0, 0, 0, F880, 0, 1, 1, 1, 0);
      cy("b_done",   1, 0, 0, 0, F880, 0, 0, 1, 0, 1);
      cy("b_idle",   1, 0, 0, 0, F880, 0, 0, 1, 0, 0);

      // Stop mid-note, then start+stop together in IDLE
      cy("c_start",  1, 1, 0, 0, F880, 0, 0, 1, 0, 0);
      cy("c_load0",  1, 0, 0, 0, F440, 1, 1, 0, 1, 0);
      cy("c_hold",   4, 0, 0, 0, F440, 0, 1, 0, 1, 0);
      cy("c_stop",   1, 0, 1, 0, F440, 0, 0, 0, 0, 0);
      cy("c_quiet", 20, 0, 0, 0, F440, 0, 0, 0, 0, 0);
      cy("d_both",   1, 1, 1, 0, F440, 0, 0, 0, 0, 0);
      cy("d_quiet",  5, 0, 0, 0, F440, 0, 0, 0, 0, 0);

      // Rewrite entry 1 while entry 0 plays
      cy("e_start",  1, 1, 0, 0, F440, 0, 0, 0, 0, 0);
      cy("e_load0",  1, 0, 0, 0, F440, 1, 1, 0, 1, 0);
      push("e_wr1",  1, 1'b1, 3'd1, 32'd200000, 16'd2, 0, 0, 0, 1, F440, 0, 1, 0, 1, 0);
      cy("e_hold0", 10, 0, 0, 0, F440, 0, 1, 0, 1, 0);
      cy("e_load1",  1, 0, 0, 0, 32'd200000, 1, 1, 1, 1, 0);
      cy("e_hold1",  7, 0, 0, 0, 32'd200000, 0, 1, 1, 1, 0);
      cy("e_done",   1, 0, 0, 0, 32'd200000, 0, 0, 1, 0, 1);

      // Rest entry plus a full eight-entry table
      wr(1, 0, 2);
      for (int i = 2; i < 8; i++) wr(AW'(i), 32'(i * 1000), 1);
      cy("f_start",  1, 1, 0, 0, 32'd200000, 0, 0, 1, 0, 0);
      cy("f_load0",  1, 0, 0, 0, F440, 1, 1, 0, 1, 0);
      cy("f_hold0", 11, 0, 0, 0, F440, 0, 1, 0, 1, 0);
      cy("f_rest",   1, 0, 0, 0, 0,    1, 0, 1, 1, 0);
      cy("f_resth",  7, 0, 0, 0, 0,    0, 0, 1, 1, 0);
      cy("f_load2",  1, 0, 0, 0, 2000, 1, 1, 2, 1, 0);
      cy("f_hold6", 19, 0, 0, 0, 6000, 0, 1, 6, 1, 0);
      cy("f_load7",  1, 0, 0, 0, 7000, 1, 1, 7, 1, 0);
      cy("f_hold7",  3, 0, 0, 0, 7000, 0, 1, 7, 1, 0);
      cy("f_done",   1, 0, 0, 0, 7000, 0, 0, 7, 0, 1);
      cy("g_start",  1, 1, 0, 1, 7000, 0, 0, 7, 0, 0);
      cy("g_load0",  1, 0, 0, 1, F440, 1, 1, 0, 1, 0);
      cy("g_hold7", 43, 0, 0, 1, 7000, 0, 1, 7, 1, 0);
      cy("g_wrap",   1, 0, 0, 1, F440, 1, 1, 0, 1, 0);
      cy("g_stop",   1, 0, 1, 1, F440, 0, 0, 0, 0, 0);

      // Entry 0 is an end marker: done without any set pulse
      wr(0, 5, 0);
      cy("h_start",  1, 1, 0, 0, F440, 0, 0, 0, 0, 0);
      cy("h_done",   1, 0, 0, 0, F440, 0, 0, 0, 0, 1);
      cy("h_idle",   1, 0, 0, 0, F440, 0, 0, 0, 0, 0);

      wr(0, F440, 3); wr(1, F880, 2);

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Asynchronous reset in the middle of playback
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      checkOutput("r_playing", F440, 1'b0, 1'b1, '0, 1'b1, 1'b0);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 checkOutput("r_async", '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("r_idle", '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
      $finish;
   end

endmodule
